// File: rtl/rgb565_to_888_stream_if.sv
// Valid/ready stream bundle: tdata (W bits), tvalid, tlast, tready.
// master drives data/valid/last and samples ready; slave is the mirror.
interface rgb565_to_888_stream_if #(
  parameter int W = 64
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/rgb565_to_888_stream.sv
// RGB565 -> RGB888 stream expander, 4 px/beat, 2-deep skid pipeline.
// Ports: clk, rst (async high); s = 64b slave stream; m = 128b master
// stream; frame_err = sticky tlast mismatch; beat_cnt = next beat index.
module rgb565_to_888_stream #(
  parameter int FRAME_BEATS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rgb565_to_888_stream_if.slave s,
  rgb565_to_888_stream_if.master m,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      beat_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_BEATS - 1);

  state_t             state_q;
  logic [127:0]       out_q;
  logic [127:0]       skid_q;
  logic               out_last_q;
  logic               skid_last_q;
  logic               m_valid_q;
  logic               s_ready_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [127:0]       data_d;
  logic               last_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               err_d;
  logic               acc;
  logic               drn;

  // Replicating the top bits keeps 0 -> 0x00 and all-ones -> 0xFF exact.
  function automatic logic [31:0] expand(input logic [15:0] p);
    return {8'h00,
            p[15:11], p[15:13],
            p[10:5],  p[10:9],
            p[4:0],   p[4:2]};
  endfunction

  assign data_d = {expand(s.tdata[63:48]),
                   expand(s.tdata[47:32]),
                   expand(s.tdata[31:16]),
                   expand(s.tdata[15:0])};

  assign acc    = s.tvalid & s_ready_q;
  assign drn    = m_valid_q & m.tready;
  assign last_d = (cnt_q == LAST_IDX);
  assign cnt_d  = last_d ? '0 : cnt_q + 1'b1;
  assign err_d  = err_q | (acc & (s.tlast != last_d));

  assign s.tready  = s_ready_q;
  assign m.tvalid  = m_valid_q;
  assign m.tdata   = out_q;
  assign m.tlast   = out_last_q;
  assign frame_err = err_q;
  assign beat_cnt  = cnt_q;

  // Occupancy FSM; s_ready/m_valid are registered alongside the state
  // so s.tready never sees m.tready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_last_q  <= 1'b0;
      skid_last_q <= 1'b0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      err_q <= err_d;
      if (acc) begin
        cnt_q <= cnt_d;
      end
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            out_q      <= data_d;
            out_last_q <= last_d;
            m_valid_q  <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            out_q      <= data_d;
            out_last_q <= last_d;
          end else if (acc) begin
            skid_q      <= data_d;
            skid_last_q <= last_d;
            s_ready_q   <= 1'b0;
            state_q     <= FULL;
          end else if (drn) begin
            m_valid_q <= 1'b0;
            state_q   <= EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            out_q      <= skid_q;
            out_last_q <= skid_last_q;
            s_ready_q  <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q   <= EMPTY;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule
